jtcontra_rom_resp: RTL
======================

# jtcontra_rom_resp

ROM-slot responder serving the game's three SDRAM read initiators (main CPU, sound CPU, ADPCM) as the far end of the `*_addr`/`*_cs` → `*_data`/`*_ok` handshake. Each slot keeps a one-word cache. Misses are arbitrated at fixed priority into a single SDRAM read port, and the fetched 16-bit word is returned as the requested byte. It sits between the game module's ROM ports and the SDRAM controller, in the `clk24` domain.

## Interface
Parameters:
- `MAIN_AW`, 17, main slot byte-address width
- `SND_AW`, 15, sound slot byte-address width
- `PCM_AW`, 17, ADPCM slot byte-address width
- `SND_OFFSET`, 22'h01_0000, word offset added to sound addresses
- `PCM_OFFSET`, 22'h01_4000, word offset added to ADPCM addresses

Ports:
- `clk` in 1: 24 MHz clock; one clock for the whole block, reset is asynchronous and active-high
- `rst` in 1: asynchronous reset, active-high
- `main_addr` in MAIN_AW: main slot byte address
- `main_cs` in 1: main slot request
- `main_data` out 8: main slot byte
- `main_ok` out 1: main slot data valid
- `snd_addr` / `snd_cs` / `snd_data` / `snd_ok`: same for the sound slot (SND_AW address)
- `pcm_addr` / `pcm_cs` / `pcm_data` / `pcm_ok`: same for the ADPCM slot (PCM_AW address)
- `sdram_addr` out 22: word address to the SDRAM controller
- `sdram_req` out 1: read request, held until acknowledged
- `sdram_ack` in 1: controller accepted the request
- `data_rdy` in 1: one-cycle strobe, `data_read` valid
- `data_read` in 16: fetched word

## Operation
- Per slot: `tag` (word address = addr>>1), `valid`, `word[15:0]`. All are cleared by reset.
- Hit: `cs & valid & tag==addr>>1`. `ok` is combinational from the cache and the current addr/cs. `data = addr[0] ? word[15:8] : word[7:0]`.
- Miss: `cs & !hit`, and the slot has no fetch in flight.
- FSM states:
  - IDLE: if any miss, select the highest-priority one (main > snd > pcm), latch the slot id and word address plus offset (main offset 0), and go to REQ.
  - REQ: assert `sdram_req` with a stable `sdram_addr`. When `sdram_ack` is seen, go to WAIT.
  - WAIT: when `data_rdy` is seen, write the selected slot's `word`/`tag`, set `valid`, and go to IDLE.
- The cache of the selected slot is invalidated at IDLE→REQ, so a stale hit cannot occur.
- A cs drop mid-fetch does not abort the fetch. The cache is still filled, and `ok` stays low while cs is low.
- An address change mid-fetch: the fill uses the latched address. The new address misses after return to IDLE and is fetched next.
- Simultaneous misses: the lower-priority slot waits. At most one fetch is outstanding.
- `sdram_ack` and `data_rdy` in the same cycle while in REQ: treat as ack followed by data. Fill the cache and go directly to IDLE.
- `data_rdy` while in IDLE or REQ without ack is ignored.
- Address arithmetic: the word address is zero-extended to 22 bits before the offset is added. The sum wraps modulo 2^22.

## Timing
- Reset values: `sdram_req`=0, `sdram_addr`=0, all `*_ok`=0, all `*_data`=0, FSM=IDLE, all `valid`=0.
- Hit latency: 0 cycles. `ok` follows addr/cs in the same cycle.
- Miss latency:
  - miss seen in cycle n; REQ, with `sdram_req` high, from n+1;
  - ack in cycle a moves the FSM to WAIT at a+1;
  - `data_rdy` in cycle d fills the cache at the edge ending d;
  - `ok` is high in d+1.
- `sdram_req` drops in the cycle after `sdram_ack`. It does not reassert before the next IDLE.
- Asynchronous reset mid-fetch: all state clears immediately. Any late `data_rdy` is ignored.

## Structure
- Shared package `jtcontra_rom_pkg`: FSM state encoding (IDLE/REQ/WAIT), slot-id encoding (MAIN=0, SND=1, PCM=2), default offset constants.
- One sub-module `jtcontra_rom_slot` (parameter AW): holds tag/valid/word, hit/miss logic, and byte select. Instantiated three times.
- The top level holds the arbiter, the FSM, and the offset adders.

## Test plan
- Reset, then `main_cs`=1, `main_addr`=17'h00003 → `sdram_req` with `sdram_addr`=22'h000001. Ack, then `data_read`=16'hA55A → `main_ok`=1 and `main_data`=8'hA5 one cycle after `data_rdy`.
- Same slot, `main_addr` switched to 17'h00002 → `main_ok` stays 1 in the same cycle with `main_data`=8'h5A and no new `sdram_req`.
- `main_cs`, `snd_cs`=1 (snd_addr 15'h0000) and `pcm_cs`=1 missing together → three fetches in the order main, snd (addr 22'h010000), pcm (addr 22'h014000). Each `ok` rises only after its own fill.
- `snd_cs` dropped during WAIT → fetch completes and `snd_ok` stays 0. Reasserting `snd_cs` at the same address → `snd_ok`=1 immediately, with no SDRAM request.
- `rst` pulsed during REQ → `sdram_req`=0 asynchronously, all `ok`=0. A `data_rdy` arriving afterwards leaves every `valid` at 0.
- `pcm_addr`=17'h1FFFF with `PCM_OFFSET`=22'h3F_FFFF → `sdram_addr` wraps to 22'h00FFFE.

Source files
------------

// File: rtl/jtcontra_rom_pkg.sv
// Shared types and constants for the Contra ROM-slot responder.
// Holds the FSM state and slot-id encodings, the latched fetch payload,
// the default SDRAM word offsets and a slot-id to one-hot helper.
package jtcontra_rom_pkg;

  localparam int unsigned SDRAM_AW = 22;
  localparam int unsigned SDRAM_DW = 16;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NSLOT    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SLOT_MAIN = 2'd0,
    SLOT_SND  = 2'd1,
    SLOT_PCM  = 2'd2
  } slot_e;

  // One outstanding SDRAM read: which slot asked and the word address sent.
  typedef struct packed {
    slot_e               slot;
    logic [SDRAM_AW-1:0] addr;
  } fetch_t;

  localparam logic [SDRAM_AW-1:0] DEF_MAIN_OFFSET = 22'h00_0000;
  localparam logic [SDRAM_AW-1:0] DEF_SND_OFFSET  = 22'h01_0000;
  localparam logic [SDRAM_AW-1:0] DEF_PCM_OFFSET  = 22'h01_4000;

  // Slot id to per-slot strobe vector.
  function automatic logic [NSLOT-1:0] slot_onehot(input slot_e s);
    case (s)
      SLOT_MAIN: return 3'b001;
      SLOT_SND:  return 3'b010;
      SLOT_PCM:  return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/jtcontra_rom_slot.sv
// One ROM slot: a single-word cache with hit/miss detection and byte select.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   addr_i, cs_i    initiator byte address and request
//   busy_i          a fetch for this slot is in flight (suppresses miss)
//   start_i         fetch launched for this slot: latch tag, drop valid
//   fill_i          fetched word arrives: store it and set valid
//   fill_data_i     fetched 16-bit word
//   data_o, ok_o    combinational byte and hit flag back to the initiator
//   miss_o          combinational miss request to the arbiter
module jtcontra_rom_slot
  import jtcontra_rom_pkg::*;
#(
  parameter int unsigned AW = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       addr_i,
  input  logic                cs_i,
  input  logic                busy_i,
  input  logic                start_i,
  input  logic                fill_i,
  input  logic [SDRAM_DW-1:0] fill_data_i,
  output logic [BYTE_W-1:0]   data_o,
  output logic                ok_o,
  output logic                miss_o
);

  localparam int unsigned TW = AW - 1;

  logic [TW-1:0]       tag_q, tag_d;
  logic                valid_q, valid_d;
  logic [SDRAM_DW-1:0] word_q, word_d;
  logic [TW-1:0]       waddr;
  logic                hit;

  assign waddr  = addr_i[AW-1:1];
  assign hit    = cs_i & valid_q & (tag_q == waddr);
  assign ok_o   = hit;
  assign miss_o = cs_i & ~hit & ~busy_i;
  assign data_o = addr_i[0] ? word_q[SDRAM_DW-1:BYTE_W] : word_q[BYTE_W-1:0];

  // The tag is captured at launch so a later address change cannot
  // mislabel the returning word.
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    word_d  = word_q;
    if (start_i) begin
      tag_d   = waddr;
      valid_d = 1'b0;
    end
    if (fill_i) begin
      word_d  = fill_data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: rtl/jtcontra_rom_resp.sv
// ROM-slot responder: serves the main CPU, sound CPU and ADPCM ROM ports
// from per-slot one-word caches and arbitrates misses (main > snd > pcm)
// into a single SDRAM read port with one fetch outstanding.
// Ports:
//   clk, rst                            clock, asynchronous active-high reset
//   main_/snd_/pcm_ addr, cs            slot requests
//   main_/snd_/pcm_ data, ok            combinational byte and data-valid
//   sdram_addr, sdram_req               registered SDRAM word address/request
//   sdram_ack, data_rdy, data_read      SDRAM controller handshake and data
module jtcontra_rom_resp
  import jtcontra_rom_pkg::*;
#(
  parameter int unsigned         MAIN_AW    = 17,
  parameter int unsigned         SND_AW     = 15,
  parameter int unsigned         PCM_AW     = 17,
  parameter logic [SDRAM_AW-1:0] SND_OFFSET = DEF_SND_OFFSET,
  parameter logic [SDRAM_AW-1:0] PCM_OFFSET = DEF_PCM_OFFSET
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MAIN_AW-1:0]  main_addr,
  input  logic                main_cs,
  output logic [BYTE_W-1:0]   main_data,
  output logic                main_ok,
  input  logic [SND_AW-1:0]   snd_addr,
  input  logic                snd_cs,
  output logic [BYTE_W-1:0]   snd_data,
  output logic                snd_ok,
  input  logic [PCM_AW-1:0]   pcm_addr,
  input  logic                pcm_cs,
  output logic [BYTE_W-1:0]   pcm_data,
  output logic                pcm_ok,
  output logic [SDRAM_AW-1:0] sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [SDRAM_DW-1:0] data_read
);

  state_e              state_q, state_d;
  fetch_t              fetch_q, fetch_d;
  logic                req_q, req_d;
  logic [NSLOT-1:0]    miss, start, fill, busy;
  logic [SDRAM_AW-1:0] main_wa, snd_wa, pcm_wa;

  // Word addresses are zero-extended before the offset; the sum wraps.
  assign main_wa = SDRAM_AW'(main_addr[MAIN_AW-1:1]) + DEF_MAIN_OFFSET;
  assign snd_wa  = SDRAM_AW'(snd_addr[SND_AW-1:1])   + SND_OFFSET;
  assign pcm_wa  = SDRAM_AW'(pcm_addr[PCM_AW-1:1])   + PCM_OFFSET;

  assign busy = (state_q != ST_IDLE) ? slot_onehot(fetch_q.slot) : '0;

  jtcontra_rom_slot #(.AW(MAIN_AW)) u_main (
    .clk         (clk),
    .rst         (rst),
    .addr_i      (main_addr),
    .cs_i        (main_cs),
    .busy_i      (busy[0]),
    .start_i     (start[0]),
    .fill_i      (fill[0]),
    .fill_data_i (data_read),
    .data_o      (main_data),
    .ok_o        (main_ok),
    .miss_o      (miss[0])
  );

  jtcontra_rom_slot #(.AW(SND_AW)) u_snd (
    .clk         (clk),
    .rst         (rst),
    .addr_i      (snd_addr),
    .cs_i        (snd_cs),
    .busy_i      (busy[1]),
    .start_i     (start[1]),
    .fill_i      (fill[1]),
    .fill_data_i (data_read),
    .data_o      (snd_data),
    .ok_o        (snd_ok),
    .miss_o      (miss[1])
  );

  jtcontra_rom_slot #(.AW(PCM_AW)) u_pcm (
    .clk         (clk),
    .rst         (rst),
    .addr_i      (pcm_addr),
    .cs_i        (pcm_cs),
    .busy_i      (busy[2]),
    .start_i     (start[2]),
    .fill_i      (fill[2]),
    .fill_data_i (data_read),
    .data_o      (pcm_data),
    .ok_o        (pcm_ok),
    .miss_o      (miss[2])
  );

  // Arbiter and fetch sequencer. data_rdy is only honoured once the
  // request has been acknowledged, including ack and data in one cycle.
  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    start   = '0;
    fill    = '0;
    case (state_q)
      ST_IDLE: begin
        if (|miss) begin
          state_d = ST_REQ;
          if (miss[0])      fetch_d = '{slot: SLOT_MAIN, addr: main_wa};
          else if (miss[1]) fetch_d = '{slot: SLOT_SND,  addr: snd_wa};
          else              fetch_d = '{slot: SLOT_PCM,  addr: pcm_wa};
          start = slot_onehot(fetch_d.slot);
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          if (data_rdy) begin
            fill    = slot_onehot(fetch_q.slot);
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (data_rdy) begin
          fill    = slot_onehot(fetch_q.slot);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fetch_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      req_q   <= req_d;
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = fetch_q.addr;

endmodule
